// File: rtl/fetch_request_unit.sv
// Fetch/data request stage in front of the MIPS control unit: arbitrates instruction fetch vs data access.
// Optional performance counters are enabled by defining REQ_PERF_CNT_EN.
module fetch_request_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] iload,
  input  logic        cu_dREN,
  input  logic        cu_dWEN,
  input  logic        cu_halt,
  output logic [31:0] instruction,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        pc_en,
  output logic        halt,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic        r_dren;
  logic        r_dwen;
  logic        r_halt;
  logic        w_dren_d;
  logic        w_dwen_d;
  logic        w_load_instr;
  logic        w_iren;
  logic        w_pc_en;
  logic [31:0] w_instr;

  // State register and held memory requests
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= FETCH;
      r_instr <= 32'h0000_0000;
      r_dren  <= 1'b0;
      r_dwen  <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_dren  <= w_dren_d;
      r_dwen  <= w_dwen_d;
      r_halt  <= (w_next_state == HALTED);
      if (w_load_instr) begin
        r_instr <= iload;
      end else begin
        r_instr <= r_instr;
      end
    end
  end

  // Next-state, request capture and combinational fetch/PC outputs
  always_comb begin
    w_next_state = r_state;
    w_dren_d     = r_dren;
    w_dwen_d     = r_dwen;
    w_load_instr = 1'b0;
    w_iren       = 1'b0;
    w_pc_en      = 1'b0;
    w_instr      = r_instr;
    case (r_state)
      FETCH: begin
        w_iren   = 1'b1;
        w_instr  = iload;
        w_dren_d = 1'b0;
        w_dwen_d = 1'b0;
        if (ihit) begin
          // Halt outranks a data request decoded from the same word
          if (cu_halt) begin
            w_next_state = HALTED;
            w_load_instr = 1'b1;
          end else if (cu_dREN || cu_dWEN) begin
            w_next_state = DATA;
            w_load_instr = 1'b1;
            w_dwen_d     = cu_dWEN;
            w_dren_d     = cu_dREN & ~cu_dWEN;
          end else begin
            w_pc_en = 1'b1;
          end
        end else begin
          w_pc_en = 1'b0;
        end
      end
      DATA: begin
        if (dhit) begin
          w_next_state = FETCH;
          w_pc_en      = 1'b1;
          w_dren_d     = 1'b0;
          w_dwen_d     = 1'b0;
        end else begin
          w_pc_en = 1'b0;
        end
      end
      HALTED: begin
        w_dren_d = 1'b0;
        w_dwen_d = 1'b0;
      end
      default: begin
        w_next_state = FETCH;
        w_dren_d     = 1'b0;
        w_dwen_d     = 1'b0;
      end
    endcase
  end

  assign instruction = w_instr;
  assign iREN        = w_iren;
  assign pc_en       = w_pc_en;
  assign dREN        = r_dren;
  assign dWEN        = r_dwen;
  assign halt        = r_halt;

`ifdef REQ_PERF_CNT_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == FETCH) && !ihit) || ((r_state == DATA) && !dhit);

  // Saturating retire/stall counters; both naturally freeze in HALTED
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_retired_cnt <= 32'h0000_0000;
      r_stall_cnt   <= 32'h0000_0000;
    end else begin
      if (w_pc_en && (r_retired_cnt != 32'hFFFF_FFFF)) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end else begin
        r_retired_cnt <= r_retired_cnt;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;
`else
  assign retired_cnt = 32'h0000_0000;
  assign stall_cnt   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Table-driven scoreboard bench for fetch_request_unit plus a hand-written reset-during-DATA sequence.
module tb_fetch_request_unit;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic        cu_dREN;
  logic        cu_dWEN;
  logic        cu_halt;
  logic [31:0] instruction;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        pc_en;
  logic        halt;
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef REQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic        cdren;
    logic        cdwen;
    logic        chalt;
    logic [31:0] e_instr;
    logic        chk_instr;
    logic        e_iren;
    logic        e_dren;
    logic        e_dwen;
    logic        e_pc;
    logic        e_halt;
    logic [31:0] e_ret;
    logic [31:0] e_stall;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  vec_t sb_q[$];

  fetch_request_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .iload(iload),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .instruction(instruction), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .pc_en(pc_en), .halt(halt), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic [31:0] il,
                       input logic r, input logic w, input logic h);
    ihit = ih; dhit = dh; iload = il; cu_dREN = r; cu_dWEN = w; cu_halt = h;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    vec_t e;
    v = vecs[idx];
    @(negedge CLK);
    drive(v.ihit, v.dhit, v.iload, v.cdren, v.cdwen, v.chalt);
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    if (e.chk_instr) check($sformatf("v%0d instruction", idx), instruction, e.e_instr);
    check($sformatf("v%0d iREN", idx), {31'd0, iREN}, {31'd0, e.e_iren});
    check($sformatf("v%0d dREN", idx), {31'd0, dREN}, {31'd0, e.e_dren});
    check($sformatf("v%0d dWEN", idx), {31'd0, dWEN}, {31'd0, e.e_dwen});
    check($sformatf("v%0d pc_en", idx), {31'd0, pc_en}, {31'd0, e.e_pc});
    check($sformatf("v%0d halt", idx), {31'd0, halt}, {31'd0, e.e_halt});
    check($sformatf("v%0d retired_cnt", idx), retired_cnt, e.e_ret);
    check($sformatf("v%0d stall_cnt", idx), stall_cnt, e.e_stall);
  endtask

  initial begin
    //        ih   dh   iload          dR   dW   hl   e_instr        ci   iR   dR   dW   pc   hl   ret     stall
    vecs[0]  = '{1'b1,1'b0,32'h2108_0001,1'b0,1'b0,1'b0,32'h2108_0001,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,cnt(0),cnt(0)};
    vecs[1]  = '{1'b1,1'b0,32'h2129_0002,1'b0,1'b0,1'b0,32'h2129_0002,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,cnt(1),cnt(0)};
    vecs[2]  = '{1'b1,1'b0,32'h214A_0003,1'b0,1'b0,1'b0,32'h214A_0003,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,cnt(2),cnt(0)};
    vecs[3]  = '{1'b1,1'b0,32'h216B_0004,1'b0,1'b0,1'b0,32'h216B_0004,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,cnt(3),cnt(0)};
    vecs[4]  = '{1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(4),cnt(0)};
    vecs[5]  = '{1'b1,1'b0,32'h8C22_0004,1'b1,1'b0,1'b0,32'h8C22_0004,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(4),cnt(1)};
    vecs[6]  = '{1'b1,1'b0,32'hDEAD_BEEF,1'b0,1'b0,1'b0,32'h8C22_0004,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,cnt(4),cnt(1)};
    vecs[7]  = '{1'b0,1'b0,32'h1234_5678,1'b0,1'b0,1'b0,32'h8C22_0004,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,cnt(4),cnt(2)};
    vecs[8]  = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h8C22_0004,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,cnt(4),cnt(3)};
    vecs[9]  = '{1'b0,1'b0,32'hAAAA_5555,1'b0,1'b0,1'b0,32'hAAAA_5555,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(5),cnt(3)};
    vecs[10] = '{1'b1,1'b0,32'hAC43_0008,1'b1,1'b1,1'b0,32'hAC43_0008,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(5),cnt(4)};
    vecs[11] = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b1,32'hAC43_0008,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,cnt(5),cnt(4)};
    vecs[12] = '{1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(6),cnt(4)};
    vecs[13] = '{1'b1,1'b0,32'hFC00_0000,1'b0,1'b1,1'b1,32'hFC00_0000,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,cnt(6),cnt(5)};
    vecs[14] = '{1'b1,1'b1,32'h1111_1111,1'b1,1'b1,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,cnt(6),cnt(5)};
    vecs[15] = '{1'b0,1'b0,32'h2222_2222,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,cnt(6),cnt(5)};

    RST = 1'b1;
    drive(1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst iREN", {31'd0, iREN}, 32'd1);
    check("rst pc_en", {31'd0, pc_en}, 32'd0);
    check("rst dREN", {31'd0, dREN}, 32'd0);
    check("rst dWEN", {31'd0, dWEN}, 32'd0);
    check("rst halt", {31'd0, halt}, 32'd0);
    check("rst instruction bypass", instruction, 32'h0BAD_F00D);
    check("rst retired_cnt", retired_cnt, 32'h0);
    check("rst stall_cnt", stall_cnt, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply_vec(i);
    end

    // Reset abandons a store in flight
    @(negedge CLK);
    RST = 1'b1;
    #2;
    check("halt cleared by reset", {31'd0, halt}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b0, 32'hAC43_0010, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    #1;
    check("store dWEN held", {31'd0, dWEN}, 32'd1);
    check("store iREN low", {31'd0, iREN}, 32'd0);
    #2;
    RST = 1'b1;
    #1;
    check("mid-DATA rst dWEN", {31'd0, dWEN}, 32'd0);
    check("mid-DATA rst iREN", {31'd0, iREN}, 32'd1);
    check("mid-DATA rst halt", {31'd0, halt}, 32'd0);
    check("mid-DATA rst pc_en", {31'd0, pc_en}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    check("post-rst dhit ignored dWEN", {31'd0, dWEN}, 32'd0);
    check("post-rst dhit ignored pc_en", {31'd0, pc_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
